// File: rtl/hpi_pkg.sv
// Shared register map, responder FSM states and STATUS bit positions for the
// HPI responder that stands in for the CY7C67200.
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'b00,
    HPI_MAILBOX = 2'b01,
    HPI_ADDRESS = 2'b10,
    HPI_STATUS  = 2'b11
  } hpi_reg_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_HOLD  = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DRIVE = 2'd3
  } hpi_rsp_state_t;

  localparam int STATUS_MBX_BIT = 0;
  localparam int STATUS_KBD_BIT = 1;

  function automatic logic [15:0] status_word(input logic kbd_flag, input logic mbx_valid);
    logic [15:0] w;
    w = 16'h0000;
    w[STATUS_KBD_BIT] = kbd_flag;
    w[STATUS_MBX_BIT] = mbx_valid;
    return w;
  endfunction

endpackage

// File: rtl/hpi_word_ram.sv
// DEPTH x 16 word store: one synchronous write port, one asynchronous read
// port, no reset so contents survive both hard and HPI soft resets.
module hpi_word_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hpi_responder.sv
// CY7C67200-side HPI responder: answers OTG_* strobes with DATA/MAILBOX/
// ADDRESS/STATUS registers over a word RAM, plus a keycode injection port.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [1:0]    OTG_ADDR,
  input  logic          OTG_CS_N,
  input  logic          OTG_RD_N,
  input  logic          OTG_WR_N,
  input  logic          OTG_RST_N,
  input  logic [15:0]   OTG_DATA_in,
  output logic [15:0]   OTG_DATA_out,
  output logic          OTG_DATA_oe,
  input  logic          kbd_we,
  input  logic [AW-1:0] kbd_addr,
  input  logic [15:0]   kbd_data,
  output logic [15:0]   mbx_to_host,
  output logic          mbx_valid,
  output logic [1:0]    o_dbg_state
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  // Handshake: a master access is a level strobe qualified by CS_N. Only the
  // rising edge of a qualified strobe starts a transaction; a read's data is
  // presented with oe until the strobe falls, a write commits once per strobe.
  logic           w_wr;
  logic           w_rd;
  logic           w_wr_rise;
  logic           w_rd_rise;
  logic           w_proto_err;
  logic           w_soft_rst;
  hpi_reg_t       w_addr_reg;

  logic           r_wr_q;
  logic           r_rd_q;
  hpi_rsp_state_t r_state;
  hpi_rsp_state_t w_state_nxt;
  logic           w_commit_wr;
  logic           w_start_rd;
  logic           w_load_out;
  logic           w_rd_done;

  logic [15:0]    r_ptr;
  logic [15:0]    r_mbx;
  logic           r_mbx_valid;
  logic           r_kbd_flag;
  hpi_reg_t       r_rd_reg;
  logic [2:0]     r_lat_cnt;
  logic [15:0]    r_data_out;
  logic           r_oe;

  logic           w_ram_we;
  logic [AW-1:0]  w_ram_waddr;
  logic [15:0]    w_ram_wdata;
  logic [15:0]    w_ram_rdata;
  logic           w_master_ram_wr;
  logic [15:0]    w_rd_data;

  assign w_wr        = ~OTG_CS_N & ~OTG_WR_N;
  assign w_rd        = ~OTG_CS_N & ~OTG_RD_N;
  assign w_wr_rise   = w_wr & ~r_wr_q;
  assign w_rd_rise   = w_rd & ~r_rd_q;
  assign w_proto_err = w_wr & w_rd;
  assign w_soft_rst  = ~OTG_RST_N;
  assign w_addr_reg  = hpi_reg_t'(OTG_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_q <= 1'b0;
      r_rd_q <= 1'b0;
    end else begin
      r_wr_q <= w_wr;
      r_rd_q <= w_rd;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit_wr = 1'b0;
    w_start_rd  = 1'b0;
    w_load_out  = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_proto_err) begin
          if (w_wr_rise) begin
            w_commit_wr = 1'b1;
            w_state_nxt = WR_HOLD;
          end else if (w_rd_rise) begin
            w_start_rd  = 1'b1;
            w_state_nxt = RD_WAIT;
          end
        end
      end
      WR_HOLD: begin
        if (!w_wr) w_state_nxt = IDLE;
      end
      RD_WAIT: begin
        if (!w_rd) begin
          w_state_nxt = IDLE;
        end else if (r_lat_cnt == 3'd0) begin
          w_load_out  = 1'b1;
          w_state_nxt = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (!w_rd) begin
          w_rd_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Soft reset abandons any transaction in flight without side effects.
    if (w_soft_rst) begin
      w_state_nxt = IDLE;
      w_commit_wr = 1'b0;
      w_start_rd  = 1'b0;
      w_load_out  = 1'b0;
      w_rd_done   = 1'b0;
    end
  end

  always_comb begin
    w_rd_data = 16'h0000;
    case (r_rd_reg)
      HPI_DATA:    w_rd_data = w_ram_rdata;
      HPI_MAILBOX: w_rd_data = r_mbx;
      HPI_ADDRESS: w_rd_data = r_ptr;
      HPI_STATUS:  w_rd_data = status_word(r_kbd_flag, r_mbx_valid);
      default:     w_rd_data = 16'h0000;
    endcase
  end

  // Single write port: a master DATA write takes the port over an injection.
  assign w_master_ram_wr = w_commit_wr && (w_addr_reg == HPI_DATA);
  assign w_ram_we        = w_master_ram_wr | kbd_we;
  assign w_ram_waddr     = w_master_ram_wr ? r_ptr[AW:1] : kbd_addr;
  assign w_ram_wdata     = w_master_ram_wr ? OTG_DATA_in : kbd_data;

  hpi_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (Clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (r_ptr[AW:1]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr       <= 16'h0000;
      r_mbx       <= 16'h0000;
      r_mbx_valid <= 1'b0;
      r_kbd_flag  <= 1'b0;
      r_rd_reg    <= HPI_DATA;
      r_lat_cnt   <= 3'd0;
      r_data_out  <= 16'h0000;
      r_oe        <= 1'b0;
    end else if (w_soft_rst) begin
      r_ptr       <= 16'h0000;
      r_mbx       <= 16'h0000;
      r_mbx_valid <= 1'b0;
      r_kbd_flag  <= 1'b0;
      r_rd_reg    <= HPI_DATA;
      r_lat_cnt   <= 3'd0;
      r_data_out  <= 16'h0000;
      r_oe        <= 1'b0;
    end else begin
      if (w_commit_wr) begin
        case (w_addr_reg)
          HPI_DATA:    r_ptr <= r_ptr + 16'd2;
          HPI_MAILBOX: begin
            r_mbx       <= OTG_DATA_in;
            r_mbx_valid <= 1'b1;
          end
          HPI_ADDRESS: r_ptr <= OTG_DATA_in;
          default:     ;
        endcase
      end

      if (w_start_rd) begin
        r_rd_reg  <= w_addr_reg;
        r_lat_cnt <= LAT_LOAD;
      end else if (r_state == RD_WAIT && r_lat_cnt != 3'd0) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end

      if (w_load_out) begin
        r_data_out <= w_rd_data;
        r_oe       <= 1'b1;
      end

      if (w_rd_done) begin
        r_data_out <= 16'h0000;
        r_oe       <= 1'b0;
        case (r_rd_reg)
          HPI_DATA:    r_ptr       <= r_ptr + 16'd2;
          HPI_MAILBOX: r_mbx_valid <= 1'b0;
          HPI_STATUS:  r_kbd_flag  <= 1'b0;
          default:     ;
        endcase
      end

      // Placed last so a same-cycle injection beats a STATUS-read clear.
      if (kbd_we) r_kbd_flag <= 1'b1;
    end
  end

  assign OTG_DATA_out = r_data_out;
  assign OTG_DATA_oe  = r_oe;
  assign mbx_to_host  = r_mbx;
  assign mbx_valid    = r_mbx_valid;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: read expectations are queued by the driver
// and matched by a monitor on each rising edge of OTG_DATA_oe.
module tb_hpi_responder;

  localparam int RD_LAT = 2;
  localparam logic [1:0] A_DATA = 2'b00;
  localparam logic [1:0] A_MBX  = 2'b01;
  localparam logic [1:0] A_ADDR = 2'b10;
  localparam logic [1:0] A_STAT = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [1:0]  OTG_ADDR;
  logic        OTG_CS_N;
  logic        OTG_RD_N;
  logic        OTG_WR_N;
  logic        OTG_RST_N;
  logic [15:0] OTG_DATA_in;
  logic [15:0] OTG_DATA_out;
  logic        OTG_DATA_oe;
  logic        kbd_we;
  logic [7:0]  kbd_addr;
  logic [15:0] kbd_data;
  logic [15:0] mbx_to_host;
  logic        mbx_valid;
  logic [1:0]  o_dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        mon_prev_oe = 1'b0;

  hpi_responder #(.DEPTH(256), .AW(8), .RD_LAT(RD_LAT)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .OTG_ADDR     (OTG_ADDR),
    .OTG_CS_N     (OTG_CS_N),
    .OTG_RD_N     (OTG_RD_N),
    .OTG_WR_N     (OTG_WR_N),
    .OTG_RST_N    (OTG_RST_N),
    .OTG_DATA_in  (OTG_DATA_in),
    .OTG_DATA_out (OTG_DATA_out),
    .OTG_DATA_oe  (OTG_DATA_oe),
    .kbd_we       (kbd_we),
    .kbd_addr     (kbd_addr),
    .kbd_data     (kbd_data),
    .mbx_to_host  (mbx_to_host),
    .mbx_valid    (mbx_valid),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new read presentation is matched against the queue head.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && OTG_DATA_oe === 1'b1 && mon_prev_oe !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got %h expected no bus drive", OTG_DATA_out);
      end else begin
        automatic logic [15:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (OTG_DATA_out !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", n, OTG_DATA_out, e);
        end
      end
    end
    mon_prev_oe = OTG_DATA_oe;
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_bus();
    OTG_CS_N = 1'b1;
    OTG_RD_N = 1'b1;
    OTG_WR_N = 1'b1;
  endtask

  task automatic hpi_write(input logic [1:0] a, input logic [15:0] d);
    tick();
    OTG_ADDR = a; OTG_DATA_in = d; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    tick();
    tick();
    idle_bus();
    tick();
  endtask

  task automatic hpi_read(input string name, input logic [1:0] a, input logic [15:0] e);
    int lat;
    exp_q.push_back(e);
    name_q.push_back(name);
    tick();
    OTG_ADDR = a; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    lat = 0;
    while (OTG_DATA_oe !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    // Edges counted include the one that first samples the strobe.
    chk({name, "_latency"}, 16'(lat), 16'(RD_LAT + 1));
    tick();
    idle_bus();
    tick();
    tick();
  endtask

  task automatic kbd_inject(input logic [7:0] a, input logic [15:0] d);
    tick();
    kbd_we = 1'b1; kbd_addr = a; kbd_data = d;
    tick();
    kbd_we = 1'b0;
  endtask

  initial begin
    int lat;
    Reset_n = 1'b0; OTG_RST_N = 1'b1; OTG_ADDR = 2'b00; OTG_DATA_in = 16'h0000;
    idle_bus();
    kbd_we = 1'b0; kbd_addr = 8'h00; kbd_data = 16'h0000;
    repeat (3) tick();
    chk("reset_oe", 16'(OTG_DATA_oe), 16'h0000);
    chk("reset_data_out", OTG_DATA_out, 16'h0000);
    chk("reset_mbx_valid", 16'(mbx_valid), 16'h0000);
    chk("reset_mbx_to_host", mbx_to_host, 16'h0000);
    chk("reset_state", 16'(o_dbg_state), 16'h0000);
    Reset_n = 1'b1;
    tick();
    hpi_read("reset_ptr", A_ADDR, 16'h0000);

    // Auto-increment
    hpi_write(A_ADDR, 16'h0100);
    hpi_write(A_DATA, 16'hAAAA);
    hpi_write(A_DATA, 16'h5555);
    hpi_read("ptr_after_two_writes", A_ADDR, 16'h0104);
    hpi_write(A_ADDR, 16'h0100);
    hpi_read("data_rd0", A_DATA, 16'hAAAA);
    hpi_read("data_rd1", A_DATA, 16'h5555);
    hpi_read("ptr_after_two_reads", A_ADDR, 16'h0104);

    // Mailbox handshake
    hpi_write(A_MBX, 16'h1234);
    chk("mbx_valid_set", 16'(mbx_valid), 16'h0001);
    chk("mbx_to_host", mbx_to_host, 16'h1234);
    hpi_read("status_mbx_full", A_STAT, 16'h0001);
    hpi_read("mbx_read", A_MBX, 16'h1234);
    chk("mbx_valid_clear", 16'(mbx_valid), 16'h0000);
    hpi_read("status_mbx_empty", A_STAT, 16'h0000);

    // Keycode injection
    kbd_inject(8'h0F, 16'h0004);
    hpi_write(A_ADDR, 16'h001E);
    hpi_read("kbd_data", A_DATA, 16'h0004);
    hpi_read("status_kbd_set", A_STAT, 16'h0002);
    hpi_read("status_kbd_clr", A_STAT, 16'h0000);

    // Master DATA write and injection collide on index 0x20
    hpi_write(A_ADDR, 16'h0040);
    tick();
    OTG_ADDR = A_DATA; OTG_DATA_in = 16'hBEEF; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    kbd_we = 1'b1; kbd_addr = 8'h20; kbd_data = 16'h0016;
    tick();
    kbd_we = 1'b0;
    tick();
    idle_bus();
    tick();
    hpi_write(A_ADDR, 16'h0040);
    hpi_read("collision_data", A_DATA, 16'hBEEF);
    hpi_read("collision_status", A_STAT, 16'h0002);

    // Pointer wrap
    hpi_write(A_ADDR, 16'hFFFE);
    hpi_write(A_DATA, 16'h1111);
    hpi_read("ptr_wrap", A_ADDR, 16'h0000);

    // Protocol error: rd and wr together change nothing
    tick();
    OTG_ADDR = A_ADDR; OTG_DATA_in = 16'h0BAD; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0; OTG_RD_N = 1'b0;
    repeat (3) tick();
    chk("proto_err_state", 16'(o_dbg_state), 16'h0000);
    idle_bus();
    tick();
    hpi_read("proto_err_ptr", A_ADDR, 16'h0000);
    chk("proto_err_mbx", 16'(mbx_valid), 16'h0000);

    // Soft reset during RD_WAIT
    hpi_write(A_ADDR, 16'h0100);
    hpi_write(A_MBX, 16'h7777);
    tick();
    OTG_ADDR = A_DATA; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    tick();
    OTG_RST_N = 1'b0;
    tick();
    OTG_RST_N = 1'b1;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      if (OTG_DATA_oe === 1'b1) lat++;
      tick();
    end
    chk("soft_rst_no_oe", 16'(lat), 16'h0000);
    chk("soft_rst_mbx_valid", 16'(mbx_valid), 16'h0000);
    idle_bus();
    tick();
    hpi_read("soft_rst_ptr", A_ADDR, 16'h0000);
    hpi_write(A_ADDR, 16'h0100);
    hpi_read("soft_rst_ram_kept", A_DATA, 16'hAAAA);

    // Read aborted in RD_WAIT leaves the pointer alone
    tick();
    OTG_ADDR = A_DATA; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    tick();
    idle_bus();
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (OTG_DATA_oe === 1'b1) lat++;
      tick();
    end
    chk("abort_no_oe", 16'(lat), 16'h0000);
    hpi_read("abort_ptr", A_ADDR, 16'h0102);

    // Hard reset while the responder is driving a read
    exp_q.push_back(16'h0102);
    name_q.push_back("rd_drive_before_reset");
    tick();
    OTG_ADDR = A_ADDR; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    lat = 0;
    while (OTG_DATA_oe !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("rd_drive_reached", 16'(OTG_DATA_oe), 16'h0001);
    tick();
    Reset_n = 1'b0;
    #1;
    chk("hard_rst_oe", 16'(OTG_DATA_oe), 16'h0000);
    chk("hard_rst_data_out", OTG_DATA_out, 16'h0000);
    idle_bus();
    tick();
    Reset_n = 1'b1;
    tick();
    hpi_read("hard_rst_ptr", A_ADDR, 16'h0000);

    repeat (3) tick();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
Synthesizable model of the CY7C67200 side of the HPI bus: it answers the OTG_* strobes driven by the FPGA-side HPI master with the HPI data, mailbox, address and status registers, backed by a word RAM.
- Used in simulation and on-board loopback builds in place of the EZ-OTG chip, so NIOS keyboard polling can run without a USB device.
- A test-side injection port writes keycode reports into the RAM, emulating the USB stack.

Parameters:
DEPTH, 256, RAM depth in 16-bit words; power of two.
AW, 8, word index width, equal to log2(DEPTH).
RD_LAT, 2, Clk cycles from read-strobe assertion to data valid; minimum 1, maximum 7.

Ports:
Clk  in  1  system clock (CLOCK_50 domain, same as the HPI master).
Reset_n  in  1  asynchronous active-low reset.
OTG_ADDR  in  2  HPI register select: 00 DATA, 01 MAILBOX, 10 ADDRESS, 11 STATUS.
OTG_CS_N  in  1  chip select, active low.
OTG_RD_N  in  1  read strobe, active low.
OTG_WR_N  in  1  write strobe, active low.
OTG_RST_N  in  1  HPI soft reset, active low, synchronous to Clk.
OTG_DATA_in  in  16  write data from the master.
OTG_DATA_out  out  16  read data to the master.
OTG_DATA_oe  out  1  high while the responder drives the data bus.
kbd_we  in  1  injection write strobe, one Clk cycle.
kbd_addr  in  AW  injection word index.
kbd_data  in  16  injection data.
mbx_to_host  out  16  last mailbox value written by the master.
mbx_valid  out  1  mailbox-full flag (STATUS bit0).

Behaviour:
- Reset values (Reset_n low, asynchronous):
  - OTG_DATA_out = 0, OTG_DATA_oe = 0.
  - Address pointer = 16'h0000, mbx_to_host = 0, mbx_valid = 0, kbd flag = 0.
  - FSM = IDLE. RAM contents undefined.
- OTG_RST_N low (synchronous): clears the same state as Reset_n but preserves RAM. The FSM returns to IDLE mid-transaction and oe drops the next cycle.
- Access qualifiers, computed from inputs sampled each cycle:
  - wr = ~CS_N & ~WR_N.
  - rd = ~CS_N & ~RD_N.
  - wr and rd together is a protocol error: both are ignored and FSM stays IDLE.
- FSM states: IDLE, WR_HOLD, RD_WAIT, RD_DRIVE.
- IDLE, wr rising: commit the write in that cycle, then go to WR_HOLD.
  - DATA: RAM[ptr[AW:1]] <= data, ptr += 2.
  - MAILBOX: mbx_to_host <= data, mbx_valid <= 1.
  - ADDRESS: ptr <= data (bit0 kept but ignored for indexing).
  - STATUS: write ignored.
- WR_HOLD: stay until wr deasserts, then IDLE. One commit per strobe regardless of strobe length.
- IDLE, rd rising: capture OTG_ADDR, load a latency counter with RD_LAT-1, go to RD_WAIT.
- RD_WAIT: count down; at 0 register read data, assert oe, go to RD_DRIVE. Data is therefore valid exactly RD_LAT cycles after rd was first seen high.
- Read data by captured address:
  - DATA: RAM[ptr[AW:1]].
  - MAILBOX: mbx_to_host.
  - ADDRESS: ptr.
  - STATUS: {14'b0, kbd_flag, mbx_valid}.
- RD_DRIVE: hold data and oe while rd stays high. On rd falling, deassert oe the next cycle and apply side effects once:
  - DATA: ptr += 2.
  - MAILBOX: mbx_valid <= 0.
  - STATUS: kbd_flag <= 0.
- rd dropping during RD_WAIT: abort, no side effects, oe never asserts.
- Pointer arithmetic: 16-bit and wraps 16'hFFFE+2 -> 16'h0000. RAM index is ptr[AW:1], so addresses beyond DEPTH alias.
- Injection: kbd_we writes RAM[kbd_addr] <= kbd_data and sets kbd_flag.
  - Same cycle as a master DATA write to the same index: the master write wins, the injection data is dropped, kbd_flag is still set.
  - Simultaneous kbd_flag set and STATUS-read clear: set wins.
- RAM is single-write: the injection write port is muxed with the master write port, and the master port has priority.

Decomposition:
- hpi_pkg holds:
  - enum hpi_reg_t {HPI_DATA=2'b00, HPI_MAILBOX=2'b01, HPI_ADDRESS=2'b10, HPI_STATUS=2'b11}.
  - enum hpi_rsp_state_t {IDLE, WR_HOLD, RD_WAIT, RD_DRIVE}.
  - Constants STATUS_MBX_BIT=0 and STATUS_KBD_BIT=1.
- Sub-module hpi_word_ram: DEPTH x 16, one write port and one asynchronous-read port, no reset. The FSM, pointer, mailbox and status logic stay in the top.

Test Plan:
- Reset: Reset_n low mid-RD_DRIVE -> oe=0 and OTG_DATA_out=0 immediately. After release, an ADDRESS read returns 16'h0000.
- Auto-increment:
  - Stimulus: ADDRESS<=16'h0100, then DATA writes 16'hAAAA, 16'h5555.
  - Response: ADDRESS reads 16'h0104. After ADDRESS<=16'h0100, DATA reads return AAAA then 5555.
  - With RD_LAT=2, each read has oe high exactly 2 cycles after rd rises.
- Mailbox handshake:
  - Stimulus: MAILBOX<=16'h1234, then STATUS read, then MAILBOX read, then STATUS read.
  - Response: mbx_valid=1 and mbx_to_host=16'h1234 the cycle after the write; first STATUS read returns 16'h0001; MAILBOX read returns 16'h1234; mbx_valid=0 after strobe release; second STATUS read returns 16'h0000.
- Keycode injection:
  - Stimulus: kbd_we with kbd_addr=8'h0F and kbd_data=16'h0004 ('A'), then ADDRESS<=16'h001E, then DATA read.
  - Response: DATA read returns 16'h0004. STATUS reads 16'h0002, then 16'h0000 on the next read.
- Collision, wrap and protocol error:
  - Master DATA write 16'hBEEF and kbd_we 16'h0016 to the same index in the same cycle -> RAM holds BEEF and STATUS bit1=1.
  - ADDRESS<=16'hFFFE, then a DATA write -> ADDRESS reads 16'h0000.
  - wr and rd asserted together -> no state change.
- Soft reset and aborted read:
  - OTG_RST_N pulse during RD_WAIT -> oe never asserts and the pointer is 0; RAM word at 16'h0100 still reads AAAA.
  - rd released in RD_WAIT -> the pointer does not advance.
